lsu_mc: RTL
===========

LSU_MC -- requirements
Module: lsu_mc

Interface
REQ-001 Parameter DW, default 32, data bus width in bits; legal values are 32 and 64.
REQ-002 Parameter AW, default 32, address width in bits.
REQ-003 Parameter SPLIT_MISALIGNED, default 1; 1 splits misaligned accesses into two bus beats, 0 rejects them with an error.
REQ-004 Port: clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 Port: rstn, input, 1, reset that is asynchronous and active-low.
REQ-006 Port: req_valid  input  1  core request valid.
REQ-007 Port: req_ready  output  1  LSU can accept a request.
REQ-008 Port: req_we  input  1  1 = store, 0 = load.
REQ-009 Port: req_size  input  2  00 byte, 01 half, 10 word, 11 dword (DW=64 only).
REQ-010 Port: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 Port: req_addr  input  AW  byte address; req_wdata  input  DW  store data, LSB-aligned.
REQ-012 Port: resp_valid  output  1  one-cycle completion pulse; resp_rdata  output  DW  extended load data; resp_err  output  1  error flag.
REQ-013 Port: bus_req  output  1; bus_gnt  input  1; bus_addr  output  AW (DW/8-aligned); bus_we  output  1; bus_be  output  DW/8; bus_wdata  output  DW.
REQ-014 Port: bus_rvalid  input  1  beat completion (loads and stores); bus_rdata  input  DW; bus_err  input  1, qualified by bus_rvalid.

Function
REQ-015 FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
REQ-016 req_ready is 1 only in IDLE; a request is accepted on req_valid & req_ready and captured into registers.
REQ-017 On accept: IDLE->REQ1, except SPLIT_MISALIGNED=0 with misaligned address, or size 11 with DW=32: IDLE->RESP with resp_err=1 and no bus activity.
REQ-018 In REQ1/REQ2 bus_req=1; bus_addr, bus_we, bus_be and bus_wdata stay stable until bus_gnt; on gnt move to WAIT1/WAIT2.
REQ-019 In WAIT1 on bus_rvalid: capture bus_rdata as beat 1; if bus_err -> RESP with resp_err=1; else if split -> REQ2; else -> RESP.
REQ-020 In WAIT2 on bus_rvalid: capture bus_rdata as beat 2 -> RESP; resp_err = bus_err.
REQ-021 RESP asserts resp_valid for exactly one cycle, then returns to IDLE.
REQ-022 Split condition: (addr mod DW/8) + 2^size > DW/8.
REQ-023 Beat 1: addr rounded down to DW/8 alignment; be1 = (((1<<2^size)-1) << off) truncated to DW/8 bits. Beat 2: beat-1 address + DW/8, modulo 2^AW; be2 = the overflow bits.
REQ-024 bus_wdata = req_wdata rotated left by off*8 on both beats; for loads, bus_we=0 and the bus_be lanes requested are as above.
REQ-025 Load result = ({beat2,beat1} >> off*8) truncated to 2^size bytes, then sign- or zero-extended to DW; resp_rdata = 0 for stores and on error.
REQ-026 Minimum latency, no split and gnt immediate: accept at T, bus_req at T+1, rvalid at T+2, resp_valid at T+3; a split adds 2 cycles.
REQ-027 bus_rvalid outside WAIT1/WAIT2 is ignored; bus_gnt outside REQ1/REQ2 is ignored.

Reset
REQ-028 rstn low forces IDLE immediately; req_ready=1 after release; all other outputs and captured registers = 0.
REQ-029 Reset in mid-transaction abandons it; no resp_valid is produced for the abandoned request.

Structure
REQ-030 Package lsu_pkg holds the size encodings, the FSM state enum and the parameter defaults.
REQ-031 A combinational sub-module lsu_align performs byte-enable generation, write rotation and load extraction/extension; lsu_mc holds the FSM and registers.

Verification
REQ-032 Aligned LW at 0x100, bus_rdata=0xDEADBEEF, gnt immediate -> resp_valid at T+3, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-033 LB at 0x103, word=0x80XXXXXX -> resp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-034 SW 0x11223344 at 0x102, SPLIT=1 -> beat1 addr 0x100, be 1100, wdata 0x33441122; beat2 addr 0x104, be 0011, same wdata.
REQ-035 LH at 0xFFFFFFFF with SPLIT=1 -> beat2 addr 0x00000000; SPLIT=0 -> no bus_req, resp_err=1 at T+1.
REQ-036 bus_err on beat 1 of a split access -> no second bus_req, resp_valid with resp_err=1; gnt held low for 5 cycles -> bus signals stable throughout.
REQ-037 rstn asserted in WAIT1 -> outputs zero in the same cycle; no resp_valid; the next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, controller states,
// parameter defaults and the beat-crossing test used by both the controller and the aligner.
package lsu_pkg;

  localparam int DW_DEFAULT    = 32;
  localparam int AW_DEFAULT    = 32;
  localparam int SPLIT_DEFAULT = 1;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ1,
    WAIT1,
    REQ2,
    WAIT2,
    RESP
  } state_e;

  // An access needs a second beat when its last byte falls past the end of the bus word.
  function automatic logic crosses_beat(input int off, input logic [1:0] size, input int nb);
    return (off + (1 << size)) > nb;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: byte enables for both beats, store-data
// rotation onto the bus lanes, and load-data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int  DW = DW_DEFAULT,
  localparam int NB = DW / 8,
  localparam int OB = $clog2(NB)
) (
  input  logic [1:0]    size,
  input  logic          zext,
  input  logic [OB-1:0] off,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] beat1,
  input  logic [DW-1:0] beat2,
  output logic          split,
  output logic [NB-1:0] be1,
  output logic [NB-1:0] be2,
  output logic [DW-1:0] wdata_rot,
  output logic [DW-1:0] rdata
);

  logic [7:0]      lanes;
  logic [2*NB-1:0] be_full;
  logic [2*DW-1:0] wdup;
  logic [2*DW-1:0] rsh;
  logic [DW-1:0]   raw;
  logic [DW-1:0]   keep;
  logic            sign;

  always_comb begin
    // NOTE: give every combinational output a default before any branch; a path that
    // leaves one unassigned makes synthesis hold the old value in a latch.
    lanes = 8'hFF;
    keep  = '1;
    sign  = 1'b0;
    split = crosses_beat(int'(off), size, NB);

    // Byte enables spill past the first bus word into the second beat.
    case (size_e'(size))
      SZ_BYTE: lanes = 8'h01;
      SZ_HALF: lanes = 8'h03;
      SZ_WORD: lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
    be_full = (2*NB)'(lanes) << off;
    be1     = be_full[NB-1:0];
    be2     = be_full[2*NB-1:NB];

    wdup      = {wdata, wdata} << {off, 3'b000};
    wdata_rot = wdup[2*DW-1:DW];

    rsh = {beat2, beat1} >> {off, 3'b000};
    raw = rsh[DW-1:0];
    case (size_e'(size))
      SZ_BYTE: begin keep = DW'(8'hFF);         sign = raw[7];    end
      SZ_HALF: begin keep = DW'(16'hFFFF);      sign = raw[15];   end
      SZ_WORD: begin keep = DW'(32'hFFFF_FFFF); sign = raw[31];   end
      default: begin keep = '1;                 sign = raw[DW-1]; end
    endcase
    rdata = (raw & keep) | ((sign && !zext) ? ~keep : '0);
  end

endmodule

// File: rtl/lsu_mc.sv
// Load/store unit controller: accepts one core request at a time, issues one or two bus
// beats (misaligned accesses may straddle a bus word) and returns a one-cycle response.
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int DW               = DW_DEFAULT,
  parameter int AW               = AW_DEFAULT,
  parameter int SPLIT_MISALIGNED = SPLIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            resp_err,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic [AW-1:0]   bus_addr,
  output logic            bus_we,
  output logic [DW/8-1:0] bus_be,
  output logic [DW-1:0]   bus_wdata,
  input  logic            bus_rvalid,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            bus_err
);

  localparam int NB = DW / 8;
  localparam int OB = $clog2(NB);

  state_e          state, state_next;
  logic            accept, reject;
  logic            we_q, zext_q, err_q;
  logic [1:0]      size_q;
  logic [AW-1:0]   addr_q, base;
  logic [DW-1:0]   wdata_q, beat1_q, beat2_q;
  logic            split;
  logic [NB-1:0]   be1, be2;
  logic [DW-1:0]   wdata_rot, ld_data;

  assign accept = req_valid && (state == IDLE);
  assign reject = ((DW == 32) && (req_size == SZ_DWORD)) ||
                  ((SPLIT_MISALIGNED == 0) && crosses_beat(int'(req_addr[OB-1:0]), req_size, NB));
  assign base   = {addr_q[AW-1:OB], {OB{1'b0}}};

  lsu_align #(.DW(DW)) u_align (
    .size      (size_q),
    .zext      (zext_q),
    .off       (addr_q[OB-1:0]),
    .wdata     (wdata_q),
    .beat1     (beat1_q),
    .beat2     (beat2_q),
    .split     (split),
    .be1       (be1),
    .be2       (be2),
    .wdata_rot (wdata_rot),
    .rdata     (ld_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples the
    // pre-edge values no matter how the simulator orders the always blocks.
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: captured request and beat registers are reset as well, so nothing from an
    // abandoned access can leak into a response after reset.
    if (!rstn) begin
      we_q    <= 1'b0;
      zext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat1_q <= '0;
      beat2_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        zext_q  <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        beat1_q <= '0;
        beat2_q <= '0;
        err_q   <= reject;
      end
      if (bus_rvalid && (state == WAIT1)) begin
        beat1_q <= bus_rdata;
        err_q   <= bus_err;
      end
      if (bus_rvalid && (state == WAIT2)) begin
        beat2_q <= bus_rdata;
        err_q   <= bus_err;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid)  state_next = reject ? RESP : REQ1;
      REQ1:    if (bus_gnt)    state_next = WAIT1;
      WAIT1:   if (bus_rvalid) state_next = (bus_err || !split) ? RESP : REQ2;
      REQ2:    if (bus_gnt)    state_next = WAIT2;
      WAIT2:   if (bus_rvalid) state_next = RESP;
      RESP:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Outputs depend on state only, so they fall to their idle values as soon as reset hits.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    bus_req    = 1'b0;
    bus_addr   = '0;
    bus_we     = 1'b0;
    bus_be     = '0;
    bus_wdata  = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      REQ1: begin
        bus_req   = 1'b1;
        bus_addr  = base;
        bus_we    = we_q;
        bus_be    = be1;
        bus_wdata = wdata_rot;
      end
      REQ2: begin
        bus_req   = 1'b1;
        bus_addr  = base + AW'(NB);
        bus_we    = we_q;
        bus_be    = be2;
        bus_wdata = wdata_rot;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? '0 : ld_data;
      end
      default: ;
    endcase
  end

endmodule
